wtg_predictor: RTL
==================

# wtg_predictor

Parametrised, sequential successor to the combinational Where-To-Go unit. The block predicts the next PC at fetch using a direct-mapped branch target buffer (BTB) with saturating counters. It resolves control-flow instructions at execute using the standard `WTG_OP_*` semantics, and emits a registered redirect when a prediction is wrong. It also maintains the BTB and counts resolved branches and mispredictions for the performance monitors.

## Interface
- `XLEN`, 32: address and data width.
- `BTB_DEPTH`, 16: number of BTB entries; must be a power of two and at least 2; `IDX = log2(BTB_DEPTH)`.
- `CTR_BITS`, 2: width of the saturating counters; must be at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc_f`  in  XLEN: fetch PC to predict.
- `pred_taken`  out  1: predict taken for `pc_f`.
- `pred_pc`  out  XLEN: predicted next PC; the BTB target if `pred_taken`, else `pc_f + 4`.
- `res_valid`  in  1: an instruction is resolving this cycle.
- `res_op`  in  `WTG_OP_BIT`: WTG operation.
- `res_pc`, `res_pc_4`  in  XLEN: PC of the resolving instruction, and that PC + 4.
- `off32`  in  32: sign-extended branch offset (words).
- `imm26`  in  26: jump immediate.
- `data_x`, `data_y`  in  XLEN: signed operands.
- `res_pred_taken`, `res_pred_pc`  in  1 / XLEN: the prediction that travelled with the instruction.
- `flush`  in  1: squash; the resolving instruction is ignored.
- `redirect_valid`  out  1: registered misprediction pulse.
- `redirect_pc`  out  XLEN: correct next PC.
- `branched`  out  1: registered; the last resolved conditional branch was taken.
- `br_cnt`, `mis_cnt`  out  32 each: resolved control instructions, and mispredictions; both wrap modulo 2^32.

## Operation
- **BTB entry:** valid, tag (`XLEN-2-IDX` bits), target (XLEN), counter (`CTR_BITS`).
- **Indexing:** index = `pc[IDX+1:2]`; tag = `pc[XLEN-1:IDX+2]`.
- **Lookup:** combinational from table state. `pred_taken` = valid & tag match & counter MSB.
- **Actual outcome per op:**
  - J32: target `data_x`, taken.
  - J26: target `{res_pc_4[31:28], imm26, 2'b00}`, taken.
  - BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ: signed compare as defined for each op; target `res_pc_4 + {off32[29:0], 2'b00}`.
  - Any other op: non-control, not taken.
- **Actual next PC:** the target if taken, else `res_pc_4`.
- **Misprediction:** `res_pred_pc` differs from the actual next PC. This covers a wrong direction, a wrong target, and a non-control op that was predicted taken.
- **BTB update** when `res_valid & !flush`:
  - Control op, hit: counter incremented (taken) or decremented (not taken), saturating. Target overwritten when taken.
  - Control op, miss, taken: allocate the entry. Counter initialised to `2^(CTR_BITS-1)` (weakly taken) for conditional branches, and to all-ones for J26/J32.
  - Control op, miss, not taken: no change.
  - Non-control op that hits with `res_pred_taken = 1`: entry invalidated (alias removal).
- **Counters:** `br_cnt` increments for every non-flushed control op; `mis_cnt` increments on every misprediction.

## Timing
- Prediction has zero latency, combinational from `pc_f`.
- Resolution to redirect takes 1 cycle: `redirect_valid` and `redirect_pc` are registered, and `redirect_valid` stays high for exactly one cycle.
- BTB write takes effect at the same edge. A lookup in the same cycle at the same index sees the old entry.
- `flush` together with `res_valid`: no redirect, no BTB update, no counter change.
- Reset values: all BTB entries invalid, counters `2^(CTR_BITS-1) - 1`, targets 0. `redirect_valid` = 0, `redirect_pc` = 0, `branched` = 0, `br_cnt` = 0, `mis_cnt` = 0.
- Reset asserted mid-operation: all of the above takes effect immediately. A pending resolution is lost and produces no redirect.
- Back-to-back resolutions are accepted every cycle; each produces its own redirect decision.

## Structure
- `WTG_OP_*` encodings and `WTG_OP_BIT` stay in `Core.vh`; this block adds no op codes.
- Sub-module `wtg_btb` holds the storage array, with one combinational read port and one synchronous write port. It has an asynchronous-clear valid array and clears all counters to `2^(CTR_BITS-1) - 1` and targets to 0 on reset.
- The top level contains outcome evaluation, counter update, the redirect registers and the performance counters.

## Test plan
- **Reset:** `pc_f = 0x00400000` -> `pred_taken = 0`, `pred_pc = 0x00400004`, `redirect_valid = 0`, both counters 0.
- **First taken branch:** BEQ with `res_pc = 0x00400010`, `data_x = data_y = 5`, `off32 = 3`, predicted not-taken -> next cycle `redirect_valid = 1`, `redirect_pc = 0x00400020`. Then `pc_f = 0x00400010` -> `pred_taken = 1`, `pred_pc = 0x00400020`, `mis_cnt = 1`.
- **Taken branch falls through:** the same BEQ with `data_x = 5`, `data_y = 6`, predicted taken -> redirect to `0x00400014`. The counter drops to `01`, so the next lookup gives `pred_taken = 0`.
- **Jump hit:** J26 with `imm26 = 0x0100000`, `res_pc_4 = 0x00400008`, correctly predicted `0x00400000` -> no redirect, `br_cnt` increments, and the counter stays saturated at `11`.
- **Alias removal:** a non-control op at a PC that hits a taken entry, with `res_pred_taken = 1` -> redirect to `res_pc_4`, and the entry reads invalid on the following cycle.
- **Flush and reset:**
  - `res_valid` with `flush = 1` on a mispredicted BNE -> no redirect and no count change.
  - Separately, `rst_n` dropped while `res_valid = 1` -> no redirect and every entry invalid.

Source files
------------

// File: rtl/wtg_predictor_pkg.sv
// Shared WTG operation encodings and op classification for the fetch predictor.
// The op codes mirror the core-wide WTG_OP_* definitions; nothing new is added here.
package wtg_predictor_pkg;

    localparam int unsigned WTG_OP_BIT = 4;

    localparam logic [WTG_OP_BIT-1:0] WTG_OP_NOP  = 4'd0;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_J32  = 4'd1;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_J26  = 4'd2;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BEQ  = 4'd3;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BNE  = 4'd4;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BLEZ = 4'd5;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BGTZ = 4'd6;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BLTZ = 4'd7;
    localparam logic [WTG_OP_BIT-1:0] WTG_OP_BGEZ = 4'd8;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_JUMP = 2'd1,
        KIND_COND = 2'd2
    } wtg_kind_t;

    // Unconditional jumps, conditional branches, or anything else.
    function automatic wtg_kind_t op_kind(input logic [WTG_OP_BIT-1:0] op);
        wtg_kind_t k;
        k = KIND_NONE;
        case (op)
            WTG_OP_J32, WTG_OP_J26: k = KIND_JUMP;
            WTG_OP_BEQ, WTG_OP_BNE, WTG_OP_BLEZ,
            WTG_OP_BGTZ, WTG_OP_BLTZ, WTG_OP_BGEZ: k = KIND_COND;
            default: k = KIND_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/wtg_btb.sv
// Direct-mapped branch target buffer storage: fetch read port, plus a write
// port that also exposes the current contents of the entry being written.
module wtg_btb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(DEPTH)-1:0]           i_rd_idx,
    output logic                               o_rd_valid,
    output logic [XLEN-3-$clog2(DEPTH):0]      o_rd_tag,
    output logic [XLEN-1:0]                    o_rd_tgt,
    output logic [CTR_BITS-1:0]                o_rd_ctr,
    input  logic [$clog2(DEPTH)-1:0]           i_wr_idx,
    output logic                               o_old_valid,
    output logic [XLEN-3-$clog2(DEPTH):0]      o_old_tag,
    output logic [XLEN-1:0]                    o_old_tgt,
    output logic [CTR_BITS-1:0]                o_old_ctr,
    input  logic                               i_wr_en,
    input  logic                               i_wr_valid,
    input  logic [XLEN-3-$clog2(DEPTH):0]      i_wr_tag,
    input  logic [XLEN-1:0]                    i_wr_tgt,
    input  logic [CTR_BITS-1:0]                i_wr_ctr
);

    localparam int unsigned IDX   = $clog2(DEPTH);
    localparam int unsigned TAG_W = XLEN - 2 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(2**(CTR_BITS-1) - 1);

    logic [DEPTH-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag [DEPTH];
    logic [XLEN-1:0]     r_tgt [DEPTH];
    logic [CTR_BITS-1:0] r_ctr [DEPTH];

    assign o_rd_valid  = r_valid[i_rd_idx];
    assign o_rd_tag    = r_tag[i_rd_idx];
    assign o_rd_tgt    = r_tgt[i_rd_idx];
    assign o_rd_ctr    = r_ctr[i_rd_idx];

    assign o_old_valid = r_valid[i_wr_idx];
    assign o_old_tag   = r_tag[i_wr_idx];
    assign o_old_tgt   = r_tgt[i_wr_idx];
    assign o_old_ctr   = r_ctr[i_wr_idx];

    // Whole table clears asynchronously; reads in the write cycle see old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tag[IDX'(i)] <= '0;
                r_tgt[IDX'(i)] <= '0;
                r_ctr[IDX'(i)] <= CTR_RST;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_tgt[i_wr_idx]   <= i_wr_tgt;
            r_ctr[i_wr_idx]   <= i_wr_ctr;
        end
    end

endmodule

// File: rtl/wtg_predictor.sv
// Fetch-time next-PC predictor with execute-time resolution, registered
// misprediction redirect, BTB maintenance and branch/mispredict counters.
module wtg_predictor
    import wtg_predictor_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BTB_DEPTH = 16,
    parameter int unsigned CTR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       pc_f,
    output logic                  pred_taken,
    output logic [XLEN-1:0]       pred_pc,
    input  logic                  res_valid,
    input  logic [WTG_OP_BIT-1:0] res_op,
    input  logic [XLEN-1:0]       res_pc,
    input  logic [XLEN-1:0]       res_pc_4,
    input  logic [31:0]           off32,
    input  logic [25:0]           imm26,
    input  logic [XLEN-1:0]       data_x,
    input  logic [XLEN-1:0]       data_y,
    input  logic                  res_pred_taken,
    input  logic [XLEN-1:0]       res_pred_pc,
    input  logic                  flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  branched,
    output logic [31:0]           br_cnt,
    output logic [31:0]           mis_cnt
);

    localparam int unsigned IDX   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = XLEN - 2 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2**(CTR_BITS-1));

    logic                w_f_valid;
    logic [TAG_W-1:0]    w_f_tag;
    logic [XLEN-1:0]     w_f_tgt;
    logic [CTR_BITS-1:0] w_f_ctr;
    logic                w_old_valid;
    logic [TAG_W-1:0]    w_old_tag;
    logic [XLEN-1:0]     w_old_tgt;
    logic [CTR_BITS-1:0] w_old_ctr;
    logic                w_wr_en;
    logic                w_wr_valid;
    logic [TAG_W-1:0]    w_wr_tag;
    logic [XLEN-1:0]     w_wr_tgt;
    logic [CTR_BITS-1:0] w_wr_ctr;

    wtg_kind_t           w_kind;
    logic                w_taken;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     w_br_tgt;
    logic [XLEN-1:0]     w_next;
    logic                w_act;
    logic                w_mis;
    logic                w_hit;
    logic [TAG_W-1:0]    w_r_tag;

    logic                r_redirect_valid;
    logic [XLEN-1:0]     r_redirect_pc;
    logic                r_branched;
    logic [31:0]         r_br_cnt;
    logic [31:0]         r_mis_cnt;

    logic                w_unused_ok;
    assign w_unused_ok = ^{off32[31:30], pc_f[1:0], res_pc[1:0]};

    wtg_btb #(
        .XLEN     (XLEN),
        .DEPTH    (BTB_DEPTH),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (pc_f[IDX+1:2]),
        .o_rd_valid  (w_f_valid),
        .o_rd_tag    (w_f_tag),
        .o_rd_tgt    (w_f_tgt),
        .o_rd_ctr    (w_f_ctr),
        .i_wr_idx    (res_pc[IDX+1:2]),
        .o_old_valid (w_old_valid),
        .o_old_tag   (w_old_tag),
        .o_old_tgt   (w_old_tgt),
        .o_old_ctr   (w_old_ctr),
        .i_wr_en     (w_wr_en),
        .i_wr_valid  (w_wr_valid),
        .i_wr_tag    (w_wr_tag),
        .i_wr_tgt    (w_wr_tgt),
        .i_wr_ctr    (w_wr_ctr)
    );

    assign pred_taken = w_f_valid && (w_f_tag == pc_f[XLEN-1:IDX+2]) && w_f_ctr[CTR_BITS-1];
    assign pred_pc    = pred_taken ? w_f_tgt : pc_f + XLEN'(4);

    assign w_br_tgt = res_pc_4 + XLEN'($signed({off32[29:0], 2'b00}));
    assign w_r_tag  = res_pc[XLEN-1:IDX+2];

    // Actual outcome of the resolving instruction.
    always_comb begin
        w_kind   = op_kind(res_op);
        w_taken  = 1'b0;
        w_target = res_pc_4;
        case (res_op)
            WTG_OP_J32: begin
                w_taken  = 1'b1;
                w_target = data_x;
            end
            WTG_OP_J26: begin
                w_taken  = 1'b1;
                w_target = {res_pc_4[XLEN-1:28], imm26, 2'b00};
            end
            WTG_OP_BEQ: begin
                w_taken  = (data_x == data_y);
                w_target = w_br_tgt;
            end
            WTG_OP_BNE: begin
                w_taken  = (data_x != data_y);
                w_target = w_br_tgt;
            end
            WTG_OP_BLEZ: begin
                w_taken  = data_x[XLEN-1] || (data_x == '0);
                w_target = w_br_tgt;
            end
            WTG_OP_BGTZ: begin
                w_taken  = !data_x[XLEN-1] && (data_x != '0);
                w_target = w_br_tgt;
            end
            WTG_OP_BLTZ: begin
                w_taken  = data_x[XLEN-1];
                w_target = w_br_tgt;
            end
            WTG_OP_BGEZ: begin
                w_taken  = !data_x[XLEN-1];
                w_target = w_br_tgt;
            end
            default: ;
        endcase
    end

    assign w_next = w_taken ? w_target : res_pc_4;
    assign w_act  = res_valid && !flush;
    assign w_mis  = (res_pred_pc != w_next);
    assign w_hit  = w_old_valid && (w_old_tag == w_r_tag);

    // BTB maintenance: train on hit, allocate on taken miss, drop aliased entries.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_valid = 1'b1;
        w_wr_tag   = w_r_tag;
        w_wr_tgt   = w_old_tgt;
        w_wr_ctr   = w_old_ctr;
        if (w_act) begin
            if (w_kind != KIND_NONE) begin
                if (w_hit) begin
                    w_wr_en = 1'b1;
                    if (w_taken) begin
                        w_wr_tgt = w_target;
                        w_wr_ctr = (w_old_ctr == CTR_MAX) ? w_old_ctr : w_old_ctr + CTR_BITS'(1);
                    end else begin
                        w_wr_ctr = (w_old_ctr == '0) ? w_old_ctr : w_old_ctr - CTR_BITS'(1);
                    end
                end else if (w_taken) begin
                    w_wr_en  = 1'b1;
                    w_wr_tgt = w_target;
                    w_wr_ctr = (w_kind == KIND_JUMP) ? CTR_MAX : CTR_WT;
                end
            end else if (w_hit && res_pred_taken) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end
        end
    end

    // Redirect pulse, branch-taken flag and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_branched       <= 1'b0;
            r_br_cnt         <= '0;
            r_mis_cnt        <= '0;
        end else begin
            r_redirect_valid <= w_act && w_mis;
            if (w_act && w_mis) begin
                r_redirect_pc <= w_next;
                r_mis_cnt     <= r_mis_cnt + 32'd1;
            end
            if (w_act && (w_kind == KIND_COND)) begin
                r_branched <= w_taken;
            end
            if (w_act && (w_kind != KIND_NONE)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign branched       = r_branched;
    assign br_cnt         = r_br_cnt;
    assign mis_cnt        = r_mis_cnt;

endmodule
